// File: rtl/pc_update_unit_pkg.sv
// ============================================================================
//  pc_update_unit_pkg : shared types and constants for the PC update stage
//  Rev 1.0
// ============================================================================
`default_nettype none

package pc_update_unit_pkg;

   typedef enum logic [1:0] {
      BR_EQ = 2'b00,
      BR_NE = 2'b01,
      BR_LE = 2'b10,
      BR_GT = 2'b11
   } br_type_t;

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_TRAP = 1'b1
   } state_t;

   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_EPC = 32'h0000_0000;

   function automatic logic pc_misaligned(input logic [31:0] pc);
      return |pc[1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_update_unit_if.sv
// ============================================================================
//  pc_update_unit_if : control-side bundle between control FSM and PC stage
//  Rev 1.0
// ============================================================================
`default_nettype none

interface pc_update_unit_if;
   logic [31:0] pc_next;
   logic        pc_write;
   logic        pc_write_cond;
   logic [1:0]  branch_type;
   logic        alu_zero;
   logic        alu_neg;
   logic        epc_write;
   logic [31:0] epc_in;
   logic        exc_ack;
   logic [31:0] pc_q;
   logic [31:0] epc_q;
   logic        pc_updated;
   logic        branch_taken;
   logic        exc_pending;

   modport master (
      output pc_next, pc_write, pc_write_cond, branch_type, alu_zero, alu_neg,
             epc_write, epc_in, exc_ack,
      input  pc_q, epc_q, pc_updated, branch_taken, exc_pending
   );

   modport slave (
      input  pc_next, pc_write, pc_write_cond, branch_type, alu_zero, alu_neg,
             epc_write, epc_in, exc_ack,
      output pc_q, epc_q, pc_updated, branch_taken, exc_pending
   );
endinterface

`default_nettype wire

// File: rtl/pc_update_unit_branch_cond_eval.sv
// ============================================================================
//  branch_cond_eval : combinational branch condition from ALU flags
//  Rev 1.0
// ============================================================================
`default_nettype none

module branch_cond_eval
   import pc_update_unit_pkg::*;
(
   input  wire logic [1:0] i_branch_type,
   input  wire logic       i_zero,
   input  wire logic       i_neg,
   output logic            o_cond
);

   always_comb begin
      o_cond = 1'b0;
      case (i_branch_type)
         BR_EQ:   o_cond = i_zero;
         BR_NE:   o_cond = ~i_zero;
         BR_LE:   o_cond = i_zero | i_neg;
         BR_GT:   o_cond = ~i_zero & ~i_neg;
         default: o_cond = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/pc_update_unit.sv
// ============================================================================
//  pc_update_unit : PC/EPC registers, branch gating and misaligned-target trap
//  Rev 1.0   optional trap enabled by define PC_ALIGN_CHECK_EN
// ============================================================================
`default_nettype none

module pc_update_unit
   import pc_update_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] RESET_EPC = DEFAULT_RESET_EPC
)(
   input  wire logic       clk,
   input  wire logic       reset,
   pc_update_unit_if.slave bus
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_epc;
   logic        r_pc_updated;
   logic        r_branch_taken;
   logic        r_exc_pending;

   logic [31:0] w_pc_nxt;
   logic [31:0] w_epc_nxt;
   logic        w_upd_nxt;
   logic        w_bt_nxt;
   logic        w_pend_nxt;

   logic        w_cond;
   logic        w_load;
   logic        w_from_cond;
   logic        w_misaligned;
   logic        w_ack;

   branch_cond_eval u_branch_cond_eval (
      .i_branch_type (bus.branch_type),
      .i_zero        (bus.alu_zero),
      .i_neg         (bus.alu_neg),
      .o_cond        (w_cond)
   );

   assign w_load      = bus.pc_write | (bus.pc_write_cond & w_cond);
   assign w_from_cond = ~bus.pc_write & bus.pc_write_cond & w_cond;

`ifdef PC_ALIGN_CHECK_EN
   assign w_misaligned = pc_misaligned(bus.pc_next);
   assign w_ack        = bus.exc_ack;
`else
   // Without the checker every load is accepted and the ack is meaningless.
   logic w_unused_ack;
   assign w_misaligned = 1'b0;
   assign w_ack        = 1'b0;
   assign w_unused_ack = bus.exc_ack;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_epc_nxt   = r_epc;
      w_upd_nxt   = 1'b0;
      w_bt_nxt    = 1'b0;
      w_pend_nxt  = r_exc_pending;
      case (r_state)
         S_RUN: begin
            if (w_load) begin
               if (w_misaligned) begin
                  w_epc_nxt   = r_pc;
                  w_pend_nxt  = 1'b1;
                  w_state_nxt = S_TRAP;
               end else begin
                  w_pc_nxt  = bus.pc_next;
                  w_upd_nxt = 1'b1;
                  w_bt_nxt  = w_from_cond;
               end
            end
         end
         S_TRAP: begin
            // Trap vector load: target alignment is deliberately not rechecked.
            if (w_ack) begin
               w_pend_nxt  = 1'b0;
               w_state_nxt = S_RUN;
               if (bus.pc_write) begin
                  w_pc_nxt  = bus.pc_next;
                  w_upd_nxt = 1'b1;
               end
            end
         end
         default: begin
            w_pend_nxt  = 1'b0;
            w_state_nxt = S_RUN;
         end
      endcase
      if (bus.epc_write) begin
         w_epc_nxt = bus.epc_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc           <= RESET_PC;
         r_epc          <= RESET_EPC;
         r_pc_updated   <= 1'b0;
         r_branch_taken <= 1'b0;
         r_exc_pending  <= 1'b0;
      end else begin
         r_pc           <= w_pc_nxt;
         r_epc          <= w_epc_nxt;
         r_pc_updated   <= w_upd_nxt;
         r_branch_taken <= w_bt_nxt;
         r_exc_pending  <= w_pend_nxt;
      end
   end

   assign bus.pc_q         = r_pc;
   assign bus.epc_q        = r_epc;
   assign bus.pc_updated   = r_pc_updated;
   assign bus.branch_taken = r_branch_taken;
`ifdef PC_ALIGN_CHECK_EN
   assign bus.exc_pending  = r_exc_pending;
`else
   logic w_unused_pend;
   assign bus.exc_pending  = 1'b0;
   assign w_unused_pend    = r_exc_pending;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_update_unit.sv
// ============================================================================
//  tb_pc_update_unit : scoreboard bench for pc_update_unit
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_update_unit;

   localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] C_RESET_EPC = 32'h0000_0000;
`ifdef PC_ALIGN_CHECK_EN
   localparam bit C_CHK = 1'b1;
`else
   localparam bit C_CHK = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] epc;
      logic        upd;
      logic        bt;
      logic        pend;
   } exp_t;

   typedef struct packed {
      logic        rst;
      logic [31:0] pcn;
      logic        pw;
      logic        pwc;
      logic [1:0]  bt;
      logic        z;
      logic        n;
      logic        ew;
      logic [31:0] ein;
      logic        ack;
   } stim_t;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   exp_t        sb[$];
   logic [31:0] m_pc, m_epc;
   logic        m_trap;

   pc_update_unit_if bus();

   pc_update_unit #(
      .RESET_PC  (C_RESET_PC),
      .RESET_EPC (C_RESET_EPC)
   ) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic stim_t mk(input logic r, input logic [31:0] pcn, input logic pw, input logic pwc,
                                input logic [1:0] bt, input logic z, input logic n,
                                input logic ew, input logic [31:0] ein, input logic ack);
      stim_t s;
      s = '{rst: r, pcn: pcn, pw: pw, pwc: pwc, bt: bt, z: z, n: n, ew: ew, ein: ein, ack: ack};
      return s;
   endfunction

   // Drive one cycle at the falling edge, predict the outcome, sample 1 unit after the rising edge.
   task automatic step(input stim_t s);
      logic cond, load, upd, btk;
      @(negedge clk);
      rst               = s.rst;
      bus.pc_next       = s.pcn;
      bus.pc_write      = s.pw;
      bus.pc_write_cond = s.pwc;
      bus.branch_type   = s.bt;
      bus.alu_zero      = s.z;
      bus.alu_neg       = s.n;
      bus.epc_write     = s.ew;
      bus.epc_in        = s.ein;
      bus.exc_ack       = s.ack;
      upd = 1'b0;
      btk = 1'b0;
      if (s.rst) begin
         m_pc   = C_RESET_PC;
         m_epc  = C_RESET_EPC;
         m_trap = 1'b0;
      end else begin
         case (s.bt)
            2'b00:   cond = s.z;
            2'b01:   cond = !s.z;
            2'b10:   cond = s.z || s.n;
            default: cond = !s.z && !s.n;
         endcase
         load = s.pw || (s.pwc && cond);
         if (!m_trap) begin
            if (load && C_CHK && (s.pcn[1:0] != 2'b00)) begin
               m_epc  = m_pc;
               m_trap = 1'b1;
            end else if (load) begin
               m_pc = s.pcn;
               upd  = 1'b1;
               btk  = !s.pw;
            end
         end else if (C_CHK && s.ack) begin
            m_trap = 1'b0;
            if (s.pw) begin
               m_pc = s.pcn;
               upd  = 1'b1;
            end
         end
         if (s.ew) m_epc = s.ein;
      end
      sb.push_back('{pc: m_pc, epc: m_epc, upd: upd, bt: btk, pend: m_trap});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t v[3];
      exp_t  e;
      v[0] = mk(1, 32'h40, 1, 0, 2'b00, 0, 0, 0, 0, 0);
      v[1] = mk(1, 32'h40, 1, 1, 2'b00, 1, 0, 1, 32'h55, 0);
      v[2] = mk(0, 32'h40, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(v[i]);
         e = sb.pop_front();
         n_tests++;
         if ({bus.pc_q, bus.epc_q, bus.pc_updated, bus.branch_taken, bus.exc_pending} !== e) begin
            n_fail++;
            $display("FAIL reset[%0d]: got pc=%h epc=%h upd=%b bt=%b pend=%b, want pc=%h epc=%h upd=%b bt=%b pend=%b",
                     i, bus.pc_q, bus.epc_q, bus.pc_updated, bus.branch_taken, bus.exc_pending,
                     e.pc, e.epc, e.upd, e.bt, e.pend);
         end
      end
      n_tests++;
      if (bus.pc_q !== C_RESET_PC || bus.pc_updated !== 1'b0 || bus.branch_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_const: got pc=%h upd=%b bt=%b, want pc=%h upd=0 bt=0",
                  bus.pc_q, bus.pc_updated, bus.branch_taken, C_RESET_PC);
      end
   endtask

   task automatic test_pc_write();
      stim_t v[3];
      exp_t  e;
      v[0] = mk(0, 32'h0000_0004, 1, 0, 2'b00, 0, 0, 0, 0, 0);
      v[1] = mk(0, 32'h0000_0100, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      v[2] = mk(0, 32'hFFFF_FFFC, 1, 0, 2'b00, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(v[i]);
         e = sb.pop_front();
         n_tests++;
         if ({bus.pc_q, bus.epc_q, bus.pc_updated, bus.branch_taken, bus.exc_pending} !== e) begin
            n_fail++;
            $display("FAIL pc_write[%0d]: got pc=%h epc=%h upd=%b bt=%b pend=%b, want pc=%h epc=%h upd=%b bt=%b pend=%b",
                     i, bus.pc_q, bus.epc_q, bus.pc_updated, bus.branch_taken, bus.exc_pending,
                     e.pc, e.epc, e.upd, e.bt, e.pend);
         end
         if (i == 0) begin
            n_tests++;
            if (bus.pc_q !== 32'h4 || bus.pc_updated !== 1'b1 || bus.branch_taken !== 1'b0) begin
               n_fail++;
               $display("FAIL pc_write_const: got pc=%h upd=%b bt=%b, want pc=00000004 upd=1 bt=0",
                        bus.pc_q, bus.pc_updated, bus.branch_taken);
            end
         end
      end
   endtask

   task automatic test_branch();
      stim_t v[10];
      exp_t  e;
      v[0] = mk(0, 32'h0000_0020, 0, 1, 2'b01, 1, 0, 0, 0, 0);  // bne, zero -> not taken
      v[1] = mk(0, 32'h0000_0020, 0, 1, 2'b01, 0, 0, 0, 0, 0);  // bne taken
      v[2] = mk(0, 32'h0000_0030, 0, 1, 2'b10, 0, 1, 0, 0, 0);  // ble taken on neg
      v[3] = mk(0, 32'h0000_0040, 0, 1, 2'b11, 0, 1, 0, 0, 0);  // bgt not taken
      v[4] = mk(0, 32'h0000_0044, 0, 1, 2'b11, 0, 0, 0, 0, 0);  // bgt taken
      v[5] = mk(0, 32'h0000_0048, 0, 1, 2'b00, 0, 0, 0, 0, 0);  // beq not taken
      v[6] = mk(0, 32'h0000_004C, 0, 1, 2'b00, 1, 0, 0, 0, 0);  // beq taken
      v[7] = mk(0, 32'h0000_0050, 1, 1, 2'b00, 1, 0, 0, 0, 0);  // both: pc_write wins
      v[8] = mk(0, 32'h0000_0060, 0, 1, 2'b10, 1, 0, 0, 0, 0);  // ble taken on zero
      v[9] = mk(0, 32'h0000_0064, 0, 0, 2'b00, 1, 0, 0, 0, 0);  // cond true, no enable
      for (int i = 0; i < 10; i++) begin
         step(v[i]);
         e = sb.pop_front();
         n_tests++;
         if ({bus.pc_q, bus.epc_q, bus.pc_updated, bus.branch_taken, bus.exc_pending} !== e) begin
            n_fail++;
            $display("FAIL branch[%0d]: got pc=%h epc=%h upd=%b bt=%b pend=%b, want pc=%h epc=%h upd=%b bt=%b pend=%b",
                     i, bus.pc_q, bus.epc_q, bus.pc_updated, bus.branch_taken, bus.exc_pending,
                     e.pc, e.epc, e.upd, e.bt, e.pend);
         end
      end
   endtask

   task automatic test_epc_write();
      stim_t v[2];
      exp_t  e;
      v[0] = mk(0, 32'h0000_0070, 1, 0, 2'b00, 0, 0, 1, 32'h1234_5678, 0);
      v[1] = mk(0, 32'h0000_0074, 0, 0, 2'b00, 0, 0, 0, 32'hDEAD_BEEF, 0);
      for (int i = 0; i < 2; i++) begin
         step(v[i]);
         e = sb.pop_front();
         n_tests++;
         if ({bus.pc_q, bus.epc_q, bus.pc_updated, bus.branch_taken, bus.exc_pending} !== e) begin
            n_fail++;
            $display("FAIL epc_write[%0d]: got pc=%h epc=%h upd=%b bt=%b pend=%b, want pc=%h epc=%h upd=%b bt=%b pend=%b",
                     i, bus.pc_q, bus.epc_q, bus.pc_updated, bus.branch_taken, bus.exc_pending,
                     e.pc, e.epc, e.upd, e.bt, e.pend);
         end
      end
   endtask

   task automatic test_misaligned();
      stim_t v[9];
      exp_t  e;
      v[0] = mk(0, 32'h0000_0100, 1, 0, 2'b00, 0, 0, 0, 0, 0);
      v[1] = mk(0, 32'h0000_0102, 1, 0, 2'b00, 0, 0, 0, 0, 0);            // misaligned
      v[2] = mk(0, 32'h0000_0200, 0, 1, 2'b00, 1, 0, 0, 0, 0);            // cond load in trap
      v[3] = mk(0, 32'h0000_0204, 1, 0, 2'b00, 0, 0, 0, 0, 0);            // pw without ack
      v[4] = mk(0, 32'h8000_0180, 1, 0, 2'b00, 0, 0, 0, 0, 1);            // vector load
      v[5] = mk(0, 32'h0000_0301, 0, 1, 2'b01, 0, 0, 1, 32'h0000_00FC, 0); // trap + epc_write
      v[6] = mk(0, 32'h0000_0000, 0, 0, 2'b00, 0, 0, 0, 0, 1);            // ack alone
      v[7] = mk(0, 32'h0000_0003, 1, 0, 2'b00, 0, 0, 0, 0, 0);            // trap again
      v[8] = mk(1, 32'h0000_0000, 0, 0, 2'b00, 0, 0, 0, 0, 0);            // reset mid-trap
      for (int i = 0; i < 9; i++) begin
         step(v[i]);
         e = sb.pop_front();
         n_tests++;
         if ({bus.pc_q, bus.epc_q, bus.pc_updated, bus.branch_taken, bus.exc_pending} !== e) begin
            n_fail++;
            $display("FAIL misaligned[%0d]: got pc=%h epc=%h upd=%b bt=%b pend=%b, want pc=%h epc=%h upd=%b bt=%b pend=%b",
                     i, bus.pc_q, bus.epc_q, bus.pc_updated, bus.branch_taken, bus.exc_pending,
                     e.pc, e.epc, e.upd, e.bt, e.pend);
         end
`ifdef PC_ALIGN_CHECK_EN
         if (i == 1) begin
            n_tests++;
            if (bus.pc_q !== 32'h100 || bus.epc_q !== 32'h100 || bus.exc_pending !== 1'b1) begin
               n_fail++;
               $display("FAIL trap_const: got pc=%h epc=%h pend=%b, want pc=00000100 epc=00000100 pend=1",
                        bus.pc_q, bus.epc_q, bus.exc_pending);
            end
         end
         if (i == 4) begin
            n_tests++;
            if (bus.pc_q !== 32'h8000_0180 || bus.exc_pending !== 1'b0) begin
               n_fail++;
               $display("FAIL vector_const: got pc=%h pend=%b, want pc=80000180 pend=0",
                        bus.pc_q, bus.exc_pending);
            end
         end
         if (i == 5) begin
            n_tests++;
            if (bus.epc_q !== 32'h0000_00FC || bus.exc_pending !== 1'b1) begin
               n_fail++;
               $display("FAIL epc_priority: got epc=%h pend=%b, want epc=000000fc pend=1",
                        bus.epc_q, bus.exc_pending);
            end
         end
`else
         if (i == 1) begin
            n_tests++;
            if (bus.pc_q !== 32'h102 || bus.exc_pending !== 1'b0 || bus.pc_updated !== 1'b1) begin
               n_fail++;
               $display("FAIL no_check_const: got pc=%h pend=%b upd=%b, want pc=00000102 pend=0 upd=1",
                        bus.pc_q, bus.exc_pending, bus.pc_updated);
            end
         end
`endif
      end
   endtask

   task automatic test_random();
      stim_t s;
      exp_t  e;
      logic [31:0] pcn;
      for (int i = 0; i < 60; i++) begin
         pcn = {$urandom} & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) pcn[1:0] = 2'($urandom_range(1, 3));
         s = mk(($urandom_range(0, 29) == 0), pcn, ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 1) == 0), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 4) == 0), {$urandom}, ($urandom_range(0, 2) == 0));
         step(s);
         e = sb.pop_front();
         n_tests++;
         if ({bus.pc_q, bus.epc_q, bus.pc_updated, bus.branch_taken, bus.exc_pending} !== e) begin
            n_fail++;
            $display("FAIL random[%0d]: got pc=%h epc=%h upd=%b bt=%b pend=%b, want pc=%h epc=%h upd=%b bt=%b pend=%b",
                     i, bus.pc_q, bus.epc_q, bus.pc_updated, bus.branch_taken, bus.exc_pending,
                     e.pc, e.epc, e.upd, e.bt, e.pend);
         end
      end
   endtask

   initial begin
      rst               = 1'b1;
      bus.pc_next       = '0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.branch_type   = 2'b00;
      bus.alu_zero      = 1'b0;
      bus.alu_neg       = 1'b0;
      bus.epc_write     = 1'b0;
      bus.epc_in        = '0;
      bus.exc_ack       = 1'b0;
      test_reset();
      test_pc_write();
      test_branch();
      test_epc_write();
      test_misaligned();
      test_random();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
